// File: rtl/rle_pkg.sv
// Shared definitions for the pixel RLE compressor / decompressor pair.
// Holds the FSM state type, default widths and the saturating counter helper.
package rle_pkg;

    localparam int RLE_DATA_WIDTH  = 8;
    localparam int RLE_COUNT_WIDTH = 8;
    localparam int RLE_STAT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        EMIT,
        DONE
    } rle_state_t;

    // Increment v, clamping at 2^w-1 (w up to 32).
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max;
        max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/rle_decompressor.sv
// Run-length decoder: expands (pixel, count) pairs into a ready/valid
// pixel stream and keeps per-frame pair/pixel statistics.
module rle_decompressor
    import rle_pkg::*;
#(
    parameter int DATA_WIDTH  = RLE_DATA_WIDTH,
    parameter int COUNT_WIDTH = RLE_COUNT_WIDTH,
    parameter int STAT_WIDTH  = RLE_STAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   last_in,
    input  logic                   valid_in,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  pixel_out,
    output logic                   valid_out,
    input  logic                   out_ready,
    output logic                   done,
    output logic                   err,
    output logic [STAT_WIDTH-1:0]  pair_count,
    output logic [STAT_WIDTH-1:0]  pixel_count
);

    rle_state_t             state, state_nx;
    logic [DATA_WIDTH-1:0]  pix_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   last_q;
    logic                   pair_xfer;
    logic                   pix_xfer;
    logic                   run_end;

    assign pair_xfer = valid_in & (state == ACCEPT);
    assign pix_xfer  = out_ready & (state == EMIT);
    assign run_end   = pix_xfer & (remaining == COUNT_WIDTH'(1));
    assign pixel_out = pix_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        valid_out = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (pair_xfer) begin
                    if (count_in != '0) state_nx = EMIT;
                    else if (last_in)   state_nx = DONE;
                end
            end
            EMIT: begin
                valid_out = 1'b1;
                if (run_end) state_nx = last_q ? DONE : ACCEPT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q       <= '0;
            remaining   <= '0;
            last_q      <= 1'b0;
            err         <= 1'b0;
            pair_count  <= '0;
            pixel_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                err         <= 1'b0;
                pair_count  <= '0;
                pixel_count <= '0;
            end
            if (pair_xfer) begin
                pix_q      <= data_in;
                remaining  <= count_in;
                last_q     <= last_in;
                pair_count <= STAT_WIDTH'(sat_inc(32'(pair_count), STAT_WIDTH));
                // A zero-length run emits nothing but flags the frame.
                if (count_in == '0) err <= 1'b1;
            end
            if (pix_xfer) begin
                remaining   <= remaining - COUNT_WIDTH'(1);
                pixel_count <= STAT_WIDTH'(sat_inc(32'(pixel_count), STAT_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_rle_decompressor.sv
// Randomised self-checking bench for rle_decompressor against a
// queue-based expansion model of each frame.
module tb_rle_decompressor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  count_in = '0;
    logic        last_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        in_ready;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic        out_ready = 1'b0;
    logic        done;
    logic        err;
    logic [15:0] pair_count;
    logic [15:0] pixel_count;

    rle_decompressor dut (
        .clk(clk), .rst(rst), .start(start),
        .data_in(data_in), .count_in(count_in), .last_in(last_in),
        .valid_in(valid_in), .in_ready(in_ready),
        .pixel_out(pixel_out), .valid_out(valid_out),
        .out_ready(out_ready), .done(done), .err(err),
        .pair_count(pair_count), .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pd[$];
    int         pc[$];
    bit         pl[$];

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int exp_pixels, exp_pairs;
    bit exp_err;
    int done_cnt, done_slot, last_pix_slot, last_pair_slot;
    int first_pair_slot, stall_bad;
    bit timed_out;

    function automatic void model();
        int sum = 0;
        exp_q.delete();
        exp_err = 0;
        foreach (pd[i]) begin
            if (pc[i] == 0) exp_err = 1;
            for (int j = 0; j < pc[i]; j++) exp_q.push_back(pd[i]);
            sum += pc[i];
        end
        exp_pixels = (sum > 65535) ? 65535 : sum;
        exp_pairs  = pd.size();
    endfunction

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready/valid
    task automatic run_frame(input int mode, input int max_cycles,
                             input bit pulse_mid);
        int idx = 0;
        int slot = 0;
        int post = 0;
        bit seen = 0;
        bit held = 0;
        bit pulsed = 0;
        logic [7:0] held_val = '0;
        got.delete();
        done_cnt = 0; done_slot = -1; last_pix_slot = -1;
        last_pair_slot = -1; first_pair_slot = -1;
        stall_bad = 0; timed_out = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (post < 3) begin
            if (slot >= max_cycles) begin
                timed_out = 1;
                break;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (slot % 4 == 0) || (slot % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < pd.size()) begin
                valid_in = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                data_in  = pd[idx];
                count_in = 8'(pc[idx]);
                last_in  = pl[idx];
            end else begin
                valid_in = 1'b0;
            end
            start = pulse_mid && valid_out && !pulsed;
            if (start) pulsed = 1;
            if (held && pixel_out !== held_val) stall_bad++;
            held     = valid_out && !out_ready;
            held_val = pixel_out;
            if (valid_out && out_ready) begin
                got.push_back(pixel_out);
                last_pix_slot = slot;
            end
            if (valid_in && in_ready) begin
                if (first_pair_slot < 0) first_pair_slot = slot;
                idx++;
                last_pair_slot = slot;
            end
            if (done) begin
                done_cnt++;
                if (!seen) done_slot = slot;
                seen = 1;
            end
            if (seen) post++;
            @(posedge clk); #1;
            slot++;
        end
        start = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic load_basic();
        pd = '{8'h01, 8'h02, 8'h03, 8'h04};
        pc = '{2, 3, 1, 2};
        pl = '{0, 0, 0, 1};
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, valid_out, done, err, pixel_out,
             pair_count, pixel_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ir=%b vo=%b d=%b e=%b px=%h pc=%0d xc=%0d required all 0",
                     in_ready, valid_out, done, err, pixel_out,
                     pair_count, pixel_count);
        end
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({in_ready, valid_out, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got ir=%b vo=%b d=%b required 000",
                     in_ready, valid_out, done);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b required 0", in_ready);
        end
    endtask

    task automatic test_basic();
        int d;
        load_basic();
        model();
        run_frame(0, 200, 0);
        d = first_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++;
            $display("FAIL basic_stream: got %0d pixels diff=%0d to=%0b required %0d pixels",
                     got.size(), d, timed_out, exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || done_slot != last_pix_slot + 1) begin
            errors++;
            $display("FAIL basic_done: got cnt=%0d slot=%0d required 1 at %0d",
                     done_cnt, done_slot, last_pix_slot + 1);
        end
        checks++;
        if (last_pix_slot - first_pair_slot + 1 != 8 + 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 12",
                     last_pix_slot - first_pair_slot + 1);
        end
        checks++;
        if (pair_count !== 16'd4 || pixel_count !== 16'd8 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_stats: got pairs=%0d pixels=%0d err=%b required 4 8 0",
                     pair_count, pixel_count, err);
        end
    endtask

    task automatic test_stall();
        int d;
        load_basic();
        model();
        run_frame(1, 400, 0);
        d = first_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++;
            $display("FAIL stall_stream: got %0d pixels diff=%0d to=%0b required %0d",
                     got.size(), d, timed_out, exp_q.size());
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d changes required 0", stall_bad);
        end
        checks++;
        if (done_cnt != 1 || done_slot != last_pix_slot + 1) begin
            errors++;
            $display("FAIL stall_done: got cnt=%0d slot=%0d required 1 at %0d",
                     done_cnt, done_slot, last_pix_slot + 1);
        end
    endtask

    task automatic test_zero_then_max();
        int d;
        pd = '{8'hAA, 8'hBB};
        pc = '{0, 255};
        pl = '{0, 1};
        model();
        run_frame(0, 2000, 0);
        d = first_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++;
            $display("FAIL max_run_stream: got %0d pixels diff=%0d required %0d",
                     got.size(), d, exp_q.size());
        end
        checks++;
        if (pair_count !== 16'd2 || pixel_count !== 16'd255 || err !== 1'b1) begin
            errors++;
            $display("FAIL max_run_stats: got pairs=%0d pixels=%0d err=%b required 2 255 1",
                     pair_count, pixel_count, err);
        end
    endtask

    task automatic test_zero_last();
        pd = '{8'h7F};
        pc = '{0};
        pl = '{1};
        model();
        run_frame(0, 100, 0);
        checks++;
        if (timed_out || got.size() != 0) begin
            errors++;
            $display("FAIL zero_last_stream: got %0d pixels required 0", got.size());
        end
        checks++;
        if (done_cnt != 1 || done_slot != last_pair_slot + 1) begin
            errors++;
            $display("FAIL zero_last_done: got cnt=%0d slot=%0d required 1 at %0d",
                     done_cnt, done_slot, last_pair_slot + 1);
        end
        checks++;
        if (err !== 1'b1 || pixel_count !== 16'd0 || pair_count !== 16'd1) begin
            errors++;
            $display("FAIL zero_last_stats: got err=%b pixels=%0d pairs=%0d required 1 0 1",
                     err, pixel_count, pair_count);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        valid_in = 1'b1;
        data_in = 8'h05;
        count_in = 8'd4;
        last_in = 1'b1;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b1 || pixel_out !== 8'h05 || pixel_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: got vo=%b px=%h cnt=%0d required 1 05 1",
                     valid_out, pixel_out, pixel_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({valid_out, in_ready} !== 2'b00 ||
            pair_count !== 16'd0 || pixel_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_abort: got vo=%b ir=%b pairs=%0d pixels=%0d required 0",
                     valid_out, in_ready, pair_count, pixel_count);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pd = '{8'h09};
        pc = '{1};
        pl = '{1};
        model();
        run_frame(0, 100, 0);
        checks++;
        if (timed_out || first_diff() != -1 || done_cnt != 1) begin
            errors++;
            $display("FAIL rst_mid_recover: got %0d pixels done=%0d required 1 pixel 09 done=1",
                     got.size(), done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        load_basic();
        model();
        run_frame(0, 200, 1);
        checks++;
        if (timed_out || first_diff() != -1 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_emit_stream: got %0d pixels done=%0d required %0d done=1",
                     got.size(), done_cnt, exp_q.size());
        end
        checks++;
        if (pair_count !== 16'(exp_pairs) || pixel_count !== 16'(exp_pixels)) begin
            errors++;
            $display("FAIL start_emit_stats: got pairs=%0d pixels=%0d required %0d %0d",
                     pair_count, pixel_count, exp_pairs, exp_pixels);
        end
    endtask

    task automatic test_random();
        int np, d;
        for (int f = 0; f < 8; f++) begin
            pd.delete(); pc.delete(); pl.delete();
            np = $urandom_range(1, 6);
            for (int i = 0; i < np; i++) begin
                pd.push_back(8'($urandom));
                pc.push_back(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12));
                pl.push_back(i == np - 1);
            end
            model();
            run_frame(2, 2000, 0);
            d = first_diff();
            checks++;
            if (timed_out || d != -1 || done_cnt != 1 ||
                done_slot != imax(last_pix_slot, last_pair_slot) + 1 ||
                stall_bad != 0) begin
                errors++;
                $display("FAIL rand_frame%0d: got %0d px diff=%0d done=%0d@%0d stall=%0d required %0d px",
                         f, got.size(), d, done_cnt, done_slot, stall_bad, exp_q.size());
            end
            checks++;
            if (pair_count !== 16'(exp_pairs) || pixel_count !== 16'(exp_pixels) ||
                err !== exp_err) begin
                errors++;
                $display("FAIL rand_stats%0d: got %0d %0d %b required %0d %0d %b",
                         f, pair_count, pixel_count, err,
                         exp_pairs, exp_pixels, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_then_max();
        test_zero_last();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_decompressor.md
Name: rle_decompressor

Overview:
- Run-length decoder; the inverse of the pixel RLE compressor.
- Accepts (pixel, count) pairs and expands each pair into `count` copies of `pixel` on a ready/valid pixel stream.
- Sits between compressed-image storage or link and the pixel-processing pipeline.
- Reports pair/pixel statistics so the bench can cross-check against the compressor's original_count/compressed_count.

Parameters:
- DATA_WIDTH, 8, pixel width.
- COUNT_WIDTH, 8, run-length field width (max run 2^COUNT_WIDTH-1).
- STAT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a decode frame.
- data_in  input  DATA_WIDTH  run pixel value.
- count_in  input  COUNT_WIDTH  run length.
- last_in  input  1  marks the final pair of the frame.
- valid_in  input  1  pair valid.
- in_ready  output  1  decoder can accept a pair.
- pixel_out  output  DATA_WIDTH  expanded pixel.
- valid_out  output  1  pixel_out valid.
- out_ready  input  1  downstream accepts pixel.
- done  output  1  one-cycle pulse after the frame's final pixel is accepted.
- err  output  1  sticky: a zero-length run was received this frame.
- pair_count  output  STAT_WIDTH  pairs accepted this frame.
- pixel_count  output  STAT_WIDTH  pixels emitted this frame.

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, valid_out, done and err are 0; pixel_out, pair_count and pixel_count are 0; internal remaining-count and last flag are cleared. Reset mid-frame aborts immediately with no further output.
- Handshake: pair transfer = valid_in & in_ready. Pixel transfer = valid_out & out_ready. While valid_out=1 and out_ready=0, pixel_out is held stable.
- IDLE:
  - in_ready=0, valid_out=0.
  - start -> ACCEPT; the same edge clears pair_count, pixel_count and err.
- ACCEPT:
  - in_ready=1.
  - On pair transfer: latch data_in, count_in, last_in; pair_count++.
  - count_in≠0 -> EMIT.
  - count_in=0: set err; the pair produces no pixel. If last_in -> DONE, else stay in ACCEPT.
- EMIT:
  - valid_out=1, pixel_out=latched pixel, in_ready=0.
  - On each pixel transfer: pixel_count++, remaining--.
  - On the transfer with remaining=1: if latched last -> DONE, else -> ACCEPT.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency and throughput:
  - First pixel of a run is valid the cycle after its pair transfer.
  - One pixel per cycle within a run when out_ready=1.
  - One bubble cycle between runs (ACCEPT).
  - A frame of P pixels in R nonzero runs takes P+R cycles from first pair to last pixel, plus 1 cycle for done.
- start outside IDLE is ignored. valid_in outside ACCEPT is ignored (not consumed).
- Statistics counters saturate at 2^STAT_WIDTH-1; they do not wrap.
- count_in = 2^COUNT_WIDTH-1 must emit exactly that many pixels; the remaining counter is COUNT_WIDTH bits and never underflows.
- Statistics and err hold their values after done until the next start.

Decomposition:
- Shared package rle_pkg holds:
  - the state enum (IDLE, ACCEPT, EMIT, DONE);
  - default DATA_WIDTH, COUNT_WIDTH, STAT_WIDTH constants;
  - the saturating-increment function.
- The compressor and this decoder share rle_pkg.
- Single module; no sub-module warranted.

Test Plan:
- Pairs (01,2),(02,3),(03,1),(04,2,last), out_ready=1 -> pixel stream 01 01 02 02 02 03 04 04; done pulses once; pixel_count=8; pair_count=4; err=0.
- Same frame with out_ready toggling 1,0,0,1 repeating -> identical stream; pixel_out stable while stalled; no pixel dropped or duplicated; done only after the 8th pixel transfer.
- Pairs (AA,0),(BB,255,last) -> no AA emitted; 255 BB pixels; err=1; pair_count=2; pixel_count=255.
- Single pair (7F,0,last) -> no valid_out; done the cycle after the pair transfer; err=1; pixel_count=0.
- rst asserted on the 2nd pixel of (05,4) -> valid_out and in_ready drop to 0 asynchronously; counters read 0. After release, start plus (09,1,last) -> exactly one 09 pixel, then done.
- start pulsed during EMIT -> ignored; counters are not cleared; the frame completes normally.
